// File: rtl/cnt_gen_param_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnt_gen_param_if : control and data bundle of the parametrised counter
// Revision 1.0
// ----------------------------------------------------------------------------
interface cnt_gen_param_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] step;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] dout;
    logic             dir;
    logic             wrap;

    modport master (
        output en, mode, step, load, load_val,
        input  dout, dir, wrap
    );

    modport slave (
        input  en, mode, step, load, load_val,
        output dout, dir, wrap
    );
endinterface
`default_nettype wire

// File: rtl/cnt_gen_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnt_gen_param : prescaled up/down/triangle/hold counter with load and wrap
// Revision 1.0
// ----------------------------------------------------------------------------
module cnt_gen_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int PRESCALE = 1,
    parameter int RST_VAL  = 0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    cnt_gen_param_if.slave   bus
);
    localparam logic [1:0]       MODE_UP   = 2'b00;
    localparam logic [1:0]       MODE_DOWN = 2'b01;
    localparam logic [1:0]       MODE_TRI  = 2'b10;
    localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W     = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT   = MAX_EXT + (WIDTH+1)'(1);

    logic             w_tick;
    logic [WIDTH-1:0] r_dout;
    logic             r_dir;
    logic             r_wrap;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_dir_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH:0]   w_dout_ext;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum;

    generate
        if (PRESCALE <= 1) begin : g_psc_bypass
            assign w_tick = bus.en;
        end else begin : g_psc_div
            localparam int             PSC_W    = $clog2(PRESCALE);
            localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
            logic [PSC_W-1:0] r_psc;

            // Load restarts the prescale period so the next tick is a full period away.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_psc <= '0;
                end else if (bus.load) begin
                    r_psc <= '0;
                end else if (bus.en) begin
                    r_psc <= (r_psc == PSC_LAST) ? '0 : r_psc + PSC_W'(1);
                end
            end

            assign w_tick = bus.en & (r_psc == PSC_LAST);
        end
    endgenerate

    assign w_dout_ext = {1'b0, r_dout};
    assign w_step_ext = {1'b0, bus.step};
    assign w_sum      = w_dout_ext + w_step_ext;

    always_comb begin
        w_dout_nxt = r_dout;
        w_dir_nxt  = r_dir;
        w_wrap_nxt = 1'b0;
        if (bus.load) begin
            w_dout_nxt = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
        end else if (w_tick) begin
            case (bus.mode)
                MODE_UP: begin
                    w_dir_nxt = 1'b1;
                    if (w_sum > MAX_EXT) begin
                        w_dout_nxt = WIDTH'(w_sum - MOD_EXT);
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_dout_nxt = WIDTH'(w_sum);
                    end
                end
                MODE_DOWN: begin
                    w_dir_nxt = 1'b0;
                    if (w_dout_ext < w_step_ext) begin
                        w_dout_nxt = WIDTH'(w_dout_ext + MOD_EXT - w_step_ext);
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_dout_nxt = WIDTH'(w_dout_ext - w_step_ext);
                    end
                end
                MODE_TRI: begin
                    // Endpoints saturate and turn; step=0 still turns at an endpoint.
                    if (r_dir) begin
                        if (w_sum >= MAX_EXT) begin
                            w_dout_nxt = MAX_W;
                            w_dir_nxt  = 1'b0;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_dout_nxt = WIDTH'(w_sum);
                        end
                    end else begin
                        if (w_dout_ext <= w_step_ext) begin
                            w_dout_nxt = '0;
                            w_dir_nxt  = 1'b1;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_dout_nxt = WIDTH'(w_dout_ext - w_step_ext);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= RST_W;
            r_dir  <= 1'b1;
            r_wrap <= 1'b0;
        end else begin
            r_dout <= w_dout_nxt;
            r_dir  <= w_dir_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.dout = r_dout;
    assign bus.dir  = r_dir;
    assign bus.wrap = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_cnt_gen_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cnt_gen_param : three counter configurations driven in lockstep and
// checked against directed sequences and an arithmetic reference model
// ----------------------------------------------------------------------------
module tb_cnt_gen_param;
    localparam int MAXV [3] = '{9, 5, 9};
    localparam int PRE  [3] = '{1, 1, 4};
    localparam int RSTV [3] = '{5, 0, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] step;
    logic       load;
    logic [7:0] load_val;

    int checks = 0;
    int errors = 0;

    int m_dout [3];
    bit m_dir  [3];
    bit m_wrap [3];
    int m_psc  [3];

    logic [7:0] obs_dout [3];
    logic       obs_dir  [3];
    logic       obs_wrap [3];

    cnt_gen_param_if #(.WIDTH(8)) ifa ();
    cnt_gen_param_if #(.WIDTH(8)) ifb ();
    cnt_gen_param_if #(.WIDTH(8)) ifc ();

    assign ifa.en = en;  assign ifa.mode = mode;  assign ifa.step = step;
    assign ifa.load = load;  assign ifa.load_val = load_val;
    assign ifb.en = en;  assign ifb.mode = mode;  assign ifb.step = step;
    assign ifb.load = load;  assign ifb.load_val = load_val;
    assign ifc.en = en;  assign ifc.mode = mode;  assign ifc.step = step;
    assign ifc.load = load;  assign ifc.load_val = load_val;

    cnt_gen_param #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1), .RST_VAL(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    cnt_gen_param #(.WIDTH(8), .MAX_VAL(5), .PRESCALE(1), .RST_VAL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    cnt_gen_param #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(4), .RST_VAL(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    always_comb begin
        obs_dout[0] = ifa.dout;  obs_dir[0] = ifa.dir;  obs_wrap[0] = ifa.wrap;
        obs_dout[1] = ifb.dout;  obs_dir[1] = ifb.dir;  obs_wrap[1] = ifb.wrap;
        obs_dout[2] = ifc.dout;  obs_dir[2] = ifc.dir;  obs_wrap[2] = ifc.wrap;
    end

    always #10 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_dout[i] = RSTV[i];
            m_dir[i]  = 1'b1;
            m_wrap[i] = 1'b0;
            m_psc[i]  = 0;
        end
    endtask

    // Reference behaviour: modular arithmetic for up/down, saturating bounce for triangle.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int nd;
            bit tick;
            m_wrap[i] = 1'b0;
            if (load) begin
                m_dout[i] = (int'(load_val) > MAXV[i]) ? MAXV[i] : int'(load_val);
                m_psc[i]  = 0;
            end else if (en) begin
                tick     = (m_psc[i] == PRE[i] - 1);
                m_psc[i] = tick ? 0 : m_psc[i] + 1;
                if (tick) begin
                    case (mode)
                        2'b00: begin
                            m_wrap[i] = (m_dout[i] + int'(step)) > MAXV[i];
                            m_dout[i] = (m_dout[i] + int'(step)) % (MAXV[i] + 1);
                            m_dir[i]  = 1'b1;
                        end
                        2'b01: begin
                            m_wrap[i] = int'(step) > m_dout[i];
                            m_dout[i] = (m_dout[i] - int'(step) + MAXV[i] + 1) % (MAXV[i] + 1);
                            m_dir[i]  = 1'b0;
                        end
                        2'b10: begin
                            if (m_dir[i]) begin
                                nd = m_dout[i] + int'(step);
                                if (nd >= MAXV[i]) begin
                                    m_dout[i] = MAXV[i]; m_dir[i] = 1'b0; m_wrap[i] = 1'b1;
                                end else m_dout[i] = nd;
                            end else begin
                                nd = m_dout[i] - int'(step);
                                if (nd <= 0) begin
                                    m_dout[i] = 0; m_dir[i] = 1'b1; m_wrap[i] = 1'b1;
                                end else m_dout[i] = nd;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] md, input logic [7:0] st,
                         input logic ld, input logic [7:0] lv);
        en = e; mode = md; step = st; load = ld; load_val = lv;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b00, 8'd0, 1'b0, 8'd0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({obs_dout[i], obs_dir[i], obs_wrap[i]} !== {8'(RSTV[i]), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_async inst%0d: dout=%0d dir=%b wrap=%b, expected dout=%0d dir=1 wrap=0",
                         i, obs_dout[i], obs_dir[i], obs_wrap[i], RSTV[i]);
            end
        end
        repeat (3) clk_step();
        rst_n = 1'b1;
        drive(1'b1, 2'b00, 8'd1, 1'b0, 8'd0);
        clk_step();
        checks++;
        if ({ifa.dout, ifb.dout, ifc.dout} !== {8'd6, 8'd1, 8'd0}) begin
            errors++;
            $display("FAIL reset_resume: a=%0d b=%0d c=%0d, expected a=6 b=1 c=0",
                     ifa.dout, ifb.dout, ifc.dout);
        end
    endtask

    task automatic test_up_wrap();
        drive(1'b1, 2'b00, 8'd1, 1'b1, 8'd0);
        clk_step();
        load = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) clk_step();
            checks++;
            if ({ifa.dout, ifa.wrap} !== {8'(k % 10), (k > 0) && (k % 10 == 0)}) begin
                errors++;
                $display("FAIL up_wrap k=%0d: dout=%0d wrap=%b, expected dout=%0d wrap=%b",
                         k, ifa.dout, ifa.wrap, k % 10, (k > 0) && (k % 10 == 0));
            end
        end
    endtask

    task automatic test_down_step();
        int exp_d [5] = '{9, 6, 3, 0, 7};
        bit exp_w [5] = '{1, 0, 0, 0, 1};
        drive(1'b1, 2'b01, 8'd3, 1'b1, 8'd2);
        clk_step();
        load = 1'b0;
        checks++;
        if (ifa.dout !== 8'd2) begin
            errors++;
            $display("FAIL down_load: dout=%0d, expected 2", ifa.dout);
        end
        for (int k = 0; k < 5; k++) begin
            clk_step();
            checks++;
            if ({ifa.dout, ifa.dir, ifa.wrap} !== {8'(exp_d[k]), 1'b0, exp_w[k]}) begin
                errors++;
                $display("FAIL down_step k=%0d: dout=%0d dir=%b wrap=%b, expected dout=%0d dir=0 wrap=%b",
                         k, ifa.dout, ifa.dir, ifa.wrap, exp_d[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_triangle();
        int exp_d [7] = '{2, 4, 5, 3, 1, 0, 2};
        bit exp_w [7] = '{0, 0, 1, 0, 0, 1, 0};
        bit exp_r [7] = '{1, 1, 0, 0, 0, 1, 1};
        drive(1'b1, 2'b00, 8'd0, 1'b0, 8'd0);
        clk_step();
        drive(1'b1, 2'b10, 8'd2, 1'b1, 8'd0);
        clk_step();
        load = 1'b0;
        checks++;
        if ({ifb.dout, ifb.dir} !== {8'd0, 1'b1}) begin
            errors++;
            $display("FAIL tri_start: dout=%0d dir=%b, expected dout=0 dir=1", ifb.dout, ifb.dir);
        end
        for (int k = 0; k < 7; k++) begin
            clk_step();
            checks++;
            if ({ifb.dout, ifb.dir, ifb.wrap} !== {8'(exp_d[k]), exp_r[k], exp_w[k]}) begin
                errors++;
                $display("FAIL triangle k=%0d: dout=%0d dir=%b wrap=%b, expected dout=%0d dir=%b wrap=%b",
                         k, ifb.dout, ifb.dir, ifb.wrap, exp_d[k], exp_r[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_prescale();
        bit en_pat [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int exp_d  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
        drive(1'b1, 2'b00, 8'd1, 1'b1, 8'd0);
        clk_step();
        load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            en = en_pat[k];
            clk_step();
            checks++;
            if ({ifc.dout, ifc.wrap} !== {8'(exp_d[k]), 1'b0}) begin
                errors++;
                $display("FAIL prescale k=%0d: dout=%0d wrap=%b, expected dout=%0d wrap=0",
                         k, ifc.dout, ifc.wrap, exp_d[k]);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(1'b1, 2'b00, 8'd1, 1'b0, 8'd0);
        repeat (3) clk_step();
        load = 1'b1; load_val = 8'd200;
        clk_step();
        load = 1'b0;
        checks++;
        if ({ifa.dout, ifa.wrap, ifb.dout, ifc.dout, ifc.wrap} !== {8'd9, 1'b0, 8'd5, 8'd9, 1'b0}) begin
            errors++;
            $display("FAIL load_clamp: a=%0d/%b b=%0d c=%0d/%b, expected a=9/0 b=5 c=9/0",
                     ifa.dout, ifa.wrap, ifb.dout, ifc.dout, ifc.wrap);
        end
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            if (k == 1) begin
                checks++;
                if ({ifa.dout, ifa.wrap} !== {8'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL load_next_tick: dout=%0d wrap=%b, expected dout=0 wrap=1",
                             ifa.dout, ifa.wrap);
                end
            end
            checks++;
            if ({ifc.dout, ifc.wrap} !== {(k == 4) ? 8'd0 : 8'd9, k == 4}) begin
                errors++;
                $display("FAIL load_psc_clear k=%0d: dout=%0d wrap=%b, expected dout=%0d wrap=%b",
                         k, ifc.dout, ifc.wrap, (k == 4) ? 0 : 9, k == 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_d [7] = '{5, 4, 3, 2, 1, 0, 5};
        bit exp_w [7] = '{0, 1, 1, 1, 1, 1, 0};
        drive(1'b1, 2'b00, 8'd5, 1'b1, 8'd0);
        clk_step();
        load = 1'b0;
        for (int k = 0; k < 7; k++) begin
            clk_step();
            checks++;
            if ({ifb.dout, ifb.wrap} !== {8'(exp_d[k]), exp_w[k]}) begin
                errors++;
                $display("FAIL back_to_back k=%0d: dout=%0d wrap=%b, expected dout=%0d wrap=%b",
                         k, ifb.dout, ifb.wrap, exp_d[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 5)),
                  $urandom_range(0, 15) == 0, 8'($urandom_range(0, 255)));
            clk_step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({obs_dout[i], obs_dir[i], obs_wrap[i]} !== {8'(m_dout[i]), m_dir[i], m_wrap[i]}) begin
                    errors++;
                    $display("FAIL random n=%0d inst%0d: dout=%0d dir=%b wrap=%b, expected dout=%0d dir=%b wrap=%b",
                             n, i, obs_dout[i], obs_dir[i], obs_wrap[i], m_dout[i], m_dir[i], m_wrap[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'b00, 8'd1, 1'b0, 8'd0);
        clk_step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({obs_dout[i], obs_dir[i], obs_wrap[i]} !== {8'(RSTV[i]), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL midcount_reset inst%0d: dout=%0d dir=%b wrap=%b, expected dout=%0d dir=1 wrap=0",
                         i, obs_dout[i], obs_dir[i], obs_wrap[i], RSTV[i]);
            end
        end
        repeat (3) clk_step();
        rst_n = 1'b1;
        repeat (2) clk_step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({obs_dout[i], obs_wrap[i]} !== {8'(m_dout[i]), m_wrap[i]}) begin
                errors++;
                $display("FAIL reset_release inst%0d: dout=%0d wrap=%b, expected dout=%0d wrap=%b",
                         i, obs_dout[i], obs_wrap[i], m_dout[i], m_wrap[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_step();
        test_triangle();
        test_prescale();
        test_load_priority();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cnt_gen_param.md
Name: cnt_gen_param

Overview:
Parametrised free-running counter/pattern generator and successor to the fixed 8-bit counter block. Generalises width and terminal value, and adds:
- prescaler, programmable step and enable;
- up / down / triangle / hold modes;
- synchronous load and a wrap/turn pulse.

It sits as a stimulus/timebase source feeding downstream datapath blocks and the standard test bench (20 ns clock, reset held 3 cycles).

Parameters:
WIDTH, 8, counter and data width in bits (2..32).
MAX_VAL, 255, terminal count; dout range is 0..MAX_VAL, and MAX_VAL <= 2^WIDTH-1.
PRESCALE, 1, enabled cycles per count tick (>=1; 1 = tick every enabled cycle).
RST_VAL, 0, dout value after reset (<= MAX_VAL).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; prescaler and counter frozen when low
mode  input  2  00 up, 01 down, 10 triangle (up/down bounce), 11 hold
step  input  WIDTH  increment per tick; must be <= MAX_VAL
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded on load
dout  output  WIDTH  registered count value
dir  output  1  registered direction, 1 = up, 0 = down
wrap  output  1  one-cycle registered pulse on wrap/turn

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is asynchronous, active-low (rst_n).
  - Reset values: dout=RST_VAL, dir=1, wrap=0, prescaler psc=0. Reset applies immediately on rst_n fall, mid-count included.
- Prescaler:
  - psc counts 0..PRESCALE-1 on cycles with en=1 and holds when en=0.
  - tick = en & (psc==PRESCALE-1); psc returns to 0 on tick.
  - PRESCALE=1 gives tick = en.
- Priority per edge: load > tick > idle.
- Load:
  - dout <= min(load_val, MAX_VAL); psc <= 0; wrap <= 0; dir unchanged.
  - Load is honoured regardless of en and mode.
- Arithmetic: all sums computed at WIDTH+1 bits; no overflow permitted.
- Mode up (00), on tick:
  - if dout+step > MAX_VAL: dout <= dout+step-(MAX_VAL+1), wrap <= 1;
  - else dout <= dout+step.
  - dir <= 1.
- Mode down (01), on tick:
  - if dout < step: dout <= dout+(MAX_VAL+1)-step, wrap <= 1;
  - else dout <= dout-step.
  - dir <= 0.
- Mode triangle (10), on tick:
  - dir=1: if dout+step >= MAX_VAL: dout <= MAX_VAL, dir <= 0, wrap <= 1; else add step.
  - dir=0: if dout <= step: dout <= 0, dir <= 1, wrap <= 1; else subtract step.
  - Endpoints saturate, never overshoot.
- Mode hold (11): dout and dir hold. psc still advances; the tick is discarded and wrap stays 0.
- step=0: dout holds on tick, except that triangle at an endpoint (dout=MAX_VAL going up, or 0 going down) still turns and pulses wrap.
- wrap:
  - Asserted for exactly the cycle in which the new dout is visible (same edge as the dout update).
  - Cleared on the next edge unless another wrap occurs.
  - Back-to-back wraps are legal, e.g. step=MAX_VAL in up mode.
- Mode change takes effect on the next tick with no flush. The current dout is kept and is continued in the new mode.
- Latency: one cycle from a tick/load cycle to updated dout. Outputs never change combinationally from inputs.
- Implementation target: 150-250 lines of RTL.

Test Plan:
1. Reset: WIDTH=8, RST_VAL=5. Drop rst_n at 2 ns, between edges → dout=5, dir=1, wrap=0 before the next clk edge; hold 3 cycles, release → counting resumes.
2. Up wrap: MAX_VAL=9, PRESCALE=1, mode=00, step=1, en=1 from 0 → dout 0,1,...,9,0. wrap=1 only in the cycle dout returns to 0; period is 10 cycles.
3. Down with step: MAX_VAL=9, mode=01, step=3, load_val=2 loaded → dout 2,9(wrap),6,3,0,7(wrap); dir=0 throughout.
4. Triangle: MAX_VAL=5, mode=10, step=2, start 0 → dout 0,2,4,5(wrap, dir→0),3,1,0(wrap, dir→1),2.
5. Prescaler and enable: PRESCALE=4, mode=00, step=1; en toggled low 2 cycles mid-period → dout increments once per 4 enabled cycles; the low cycles stretch the period to 6 clocks.
6. Load priority and clamp: MAX_VAL=9, load=1 with load_val=200 on a tick cycle, mode=00 → dout=9, wrap=0, psc reset. Next tick → dout=0, wrap=1.
